// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared state type and default constants for the data-memory stage
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam int DEF_DATA_BASE   = 1024;
    localparam int DEF_WAIT_CYCLES = 5;

endpackage

// File: rtl/Register.sv
// rtl/Register.sv - enabled register with asynchronous active-low clear
module Register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - per-phase wait counter, wraps at WAIT_CYCLES-1 and flags it
module sram_wait_counter #(
    parameter int  WAIT_CYCLES = 5,
    localparam int CNT_W       = $clog2(WAIT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    assign last = (count == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - 32-bit load/store over two 16-bit async SRAM phases; MEM_RANGE_CHECK_EN adds addr_err
module mem_stage_sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int BIT_NUMBER  = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int DATA_BASE   = DEF_DATA_BASE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [BIT_NUMBER-1:0]  address,
    input  logic [BIT_NUMBER-1:0]  write_data,
    output logic [BIT_NUMBER-1:0]  read_data,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic                   addr_err
`endif
);

    localparam int CNT_W = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WAIT_CYCLES - 2);

    mem_state_t             state_q;
    logic                   wr_q;
    logic [BIT_NUMBER-1:0]  wdata_q;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [SRAM_ADDR_W-1:0] sram_addr_q;
    logic                   we_n_q;
    logic                   oe_n_q;

    logic                   req;
    logic [BIT_NUMBER-1:0]  offset;
    logic [BIT_NUMBER-1:0]  word_full;
    logic [SRAM_ADDR_W-2:0] word_trunc;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_last;
    logic                   in_phase;
    logic                   dq_drive;
    logic [15:0]            dq_out;
    logic                   rd_lo_en;
    logic                   rd_hi_en;
    logic                   unused_bits;

    assign req        = rd_en | wr_en;
    assign offset     = address - BIT_NUMBER'(DATA_BASE);
    assign word_full  = offset >> 2;
    assign word_trunc = word_full[SRAM_ADDR_W-2:0];
    assign unused_bits = ^{word_full[BIT_NUMBER-1:SRAM_ADDR_W-1], offset[1:0]};

`ifdef MEM_RANGE_CHECK_EN
    logic addr_err_q;
    logic addr_bad;
    assign addr_bad = (address < BIT_NUMBER'(DATA_BASE)) ||
                      (word_full[BIT_NUMBER-1:SRAM_ADDR_W-1] != '0);
    assign addr_err = addr_err_q;
`endif

    assign in_phase = (state_q == LOW) || (state_q == HIGH);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == IDLE),
        .en   (in_phase),
        .count(cnt),
        .last (cnt_last)
    );

    // Strobes are registered; WE_N is raised one count early so DQ is held across its rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            word_q      <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
            addr_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q    <= wr_en;
                        wdata_q <= write_data;
                        word_q  <= word_trunc;
`ifdef MEM_RANGE_CHECK_EN
                        if (addr_bad) begin
                            state_q    <= DONE;
                            addr_err_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q     <= LOW;
                            sram_addr_q <= {word_trunc, 1'b0};
                            we_n_q      <= !wr_en;
                            oe_n_q      <= wr_en;
                        end
                    end
                end
                LOW: begin
                    if (cnt_last) begin
                        state_q     <= HIGH;
                        sram_addr_q <= {word_q, 1'b1};
                        we_n_q      <= !wr_q;
                    end else if (cnt == PRE_LAST) begin
                        we_n_q <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_last) begin
                        state_q <= DONE;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                    end else if (cnt == PRE_LAST) begin
                        we_n_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
`ifdef MEM_RANGE_CHECK_EN
                    addr_err_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dq_drive  = wr_q && in_phase;
    assign dq_out    = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ   = dq_drive ? dq_out : 16'hzzzz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;

    assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

    assign rd_lo_en = (state_q == LOW)  && !wr_q && cnt_last;
    assign rd_hi_en = (state_q == HIGH) && !wr_q && cnt_last;

    Register #(.WIDTH(16)) u_rd_lo (
        .clk(clk),
        .rst(rst),
        .en (rd_lo_en),
        .d  (SRAM_DQ),
        .q  (read_data[15:0])
    );

    Register #(.WIDTH(16)) u_rd_hi (
        .clk(clk),
        .rst(rst),
        .en (rd_hi_en),
        .d  (SRAM_DQ),
        .q  (read_data[31:16])
    );

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - scoreboard bench with async SRAM model; MEM_RANGE_CHECK_EN enables the range test
module tb_mem_stage_sram_ctrl;

    localparam int W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
`ifdef MEM_RANGE_CHECK_EN
    logic        addr_err;
`endif

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_OE_N (sram_oe_n)
`ifdef MEM_RANGE_CHECK_EN
        ,
        .addr_err  (addr_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        err;
    } done_t;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    done_t done_q[$];
    wr_t   wr_exp_q[$];

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    int we_low = 0;
    bit busy = 0;
    bit model_en = 0;
    bit oe_seen = 0;

    logic [15:0] mem [0:255];

    assign sram_dq = !sram_oe_n ? mem[sram_addr[7:0]] : 16'hzzzz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // SRAM latches data on the rising write strobe; each strobe is checked against the write scoreboard.
    always @(posedge sram_we_n) begin
        if (model_en) begin
            wr_t e;
            mem[sram_addr[7:0]] = sram_dq;
            if (wr_exp_q.size() == 0) begin
                chk("wr_unexpected", {14'd0, sram_addr}, 32'hFFFF_FFFF);
            end else begin
                e = wr_exp_q.pop_front();
                chk("wr_addr", {14'd0, sram_addr}, {14'd0, e.addr});
                chk("wr_dq_at_rise", {16'd0, sram_dq}, {16'd0, e.data});
                chk("we_low_cycles", we_low, W - 1);
            end
            we_low = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            busy = 0;
        end else begin
            if (!sram_we_n) we_low++;
            if (!sram_oe_n) oe_seen = 1;
            if (!ready && !busy) begin
                busy = 1;
                start_cyc = cyc;
            end else if (ready && busy) begin
                done_t e;
                busy = 0;
                if (done_q.size() == 0) begin
                    chk("done_unexpected", read_data, 32'hFFFF_FFFF);
                end else begin
                    e = done_q.pop_front();
                    chk("read_data", read_data, e.rdata);
                    chk("latency", cyc - start_cyc, e.lat);
`ifdef MEM_RANGE_CHECK_EN
                    chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
`endif
                end
            end
        end
    end

    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #2;
        wr_en = w; rd_en = r; address = a; write_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 100);
        if (!ready) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL access_timeout: got ready=0 expected ready=1 within 100 cycles");
        end
        @(posedge clk); #2;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        model_en = 1;

        wr_exp_q.push_back('{addr: 18'd0, data: 16'hBEEF});
        wr_exp_q.push_back('{addr: 18'd1, data: 16'hDEAD});
        done_q.push_back('{rdata: 32'h0, lat: 11, err: 1'b0});
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        chk("sram0", {16'd0, mem[0]}, 32'h0000BEEF);
        chk("sram1", {16'd0, mem[1]}, 32'h0000DEAD);

        done_q.push_back('{rdata: 32'hDEADBEEF, lat: 11, err: 1'b0});
        access(1'b0, 1'b1, 32'd1024, 32'h0);

        wr_exp_q.push_back('{addr: 18'd2, data: 16'h5A5A});
        wr_exp_q.push_back('{addr: 18'd3, data: 16'hA5A5});
        done_q.push_back('{rdata: 32'hDEADBEEF, lat: 11, err: 1'b0});
        access(1'b1, 1'b0, 32'd1028, 32'hA5A55A5A);

        wr_exp_q.push_back('{addr: 18'd4, data: 16'h5678});
        wr_exp_q.push_back('{addr: 18'd5, data: 16'h1234});
        done_q.push_back('{rdata: 32'hDEADBEEF, lat: 11, err: 1'b0});
        access(1'b1, 1'b1, 32'd1032, 32'h12345678);

        done_q.push_back('{rdata: 32'h12345678, lat: 11, err: 1'b0});
        access(1'b0, 1'b1, 32'd1034, 32'h0);

        repeat (20) begin
            @(negedge clk);
            chk("idle_ready_strobes", {29'd0, ready, sram_we_n, sram_oe_n}, 32'd7);
        end

        mem[0] = 16'hF00D;
        mem[1] = 16'hCAFE;
        @(posedge clk); #2;
        rd_en = 1'b1; address = 32'd1024;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        chk("midrst_read_data", read_data, 32'd0);
        @(posedge clk); #2 rst = 1'b1;
        done_q.push_back('{rdata: 32'hCAFEF00D, lat: 11, err: 1'b0});
        access(1'b0, 1'b1, 32'd1024, 32'h0);

`ifdef MEM_RANGE_CHECK_EN
        oe_seen = 0;
        done_q.push_back('{rdata: 32'hCAFEF00D, lat: 1, err: 1'b1});
        access(1'b0, 1'b1, 32'd512, 32'h0);
        chk("range_no_oe", {31'd0, oe_seen}, 32'd0);
        @(negedge clk);
        chk("range_err_cleared", {31'd0, addr_err}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("done_q_drained", done_q.size(), 32'd0);
        chk("wr_q_drained", wr_exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Data-memory access stage of the ARM pipeline, sitting between the EXE stage register and the MEM stage register. Converts a 32-bit load/store issued by EXE into two 16-bit accesses on the external asynchronous SRAM, holds the pipeline via `ready` until the access finishes, and presents the loaded word on `read_data` for capture by the MEM stage register.

## Interface
- `BIT_NUMBER`, 32: data/address width.
- `SRAM_ADDR_W`, 18: external SRAM half-word address width.
- `WAIT_CYCLES`, 5: cycles per 16-bit SRAM phase; legal range ≥2.
- `DATA_BASE`, 1024: byte address of data-memory word 0.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `rd_en` in 1: load request; EXE stage `Mem_R_en`.
- `wr_en` in 1: store request; EXE stage `Mem_W_en`.
- `address` in BIT_NUMBER: byte address; EXE stage `ALU_result`.
- `write_data` in BIT_NUMBER: store data; EXE stage `Val_Rm`.
- `read_data` out BIT_NUMBER: last loaded word.
- `ready` out 1: access complete; when low, upstream freezes.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out SRAM_ADDR_W: half-word address.
- `SRAM_WE_N` out 1: active-low write strobe.
- `SRAM_OE_N` out 1: active-low output enable.
- `addr_err` out 1: present only with `MEM_RANGE_CHECK_EN`.

## Operation
- Address map: `word = (address - DATA_BASE) >> 2`. Low half at `SRAM_ADDR = {word, 1'b0}`, high half at `{word, 1'b1}`. Truncate to SRAM_ADDR_W. `address[1:0]` is ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - `wr_en` or `rd_en` → LOW, counter cleared.
  - Request type is latched. If both are high, the write wins.
- LOW / HIGH:
  - Counter runs 0..WAIT_CYCLES-1.
  - At count WAIT_CYCLES-1: LOW → HIGH, HIGH → DONE.
- DONE → IDLE unconditionally.
- Read phase:
  - `SRAM_OE_N` = 0 and `SRAM_DQ` is tri-stated.
  - On the last cycle of the phase, `SRAM_DQ` is sampled into `read_data[15:0]` (LOW) or `read_data[31:16]` (HIGH).
- Write phase:
  - `SRAM_DQ` is driven with `write_data[15:0]` (LOW) or `write_data[31:16]` (HIGH).
  - `SRAM_WE_N` = 0 for counts 0..WAIT_CYCLES-2 and 1 on the last count, so data is held across the rising strobe.
- Outside LOW/HIGH: `SRAM_WE_N` = `SRAM_OE_N` = 1, DQ tri-stated, `SRAM_ADDR` holds its last value.
- `ready`:
  - Combinational: 1 in IDLE with no request, 1 in DONE, 0 otherwise.
  - It is 0 in the IDLE cycle where a request is first seen.
- `read_data` is updated only by reads. It holds its value through writes and idle time.
- Request inputs are ignored after IDLE. If a request drops mid-access, the access still completes and DONE still occurs.

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `SRAM_WE_N` 1, `SRAM_OE_N` 1, DQ high-Z, `SRAM_ADDR` 0, `addr_err` 0.
- Reset asserted mid-access returns to IDLE immediately. A partial write may have reached SRAM; a partial read does not update `read_data`.
- Access latency: a request seen in cycle 0 gives `ready` = 1 in cycle 2·WAIT_CYCLES+1. That is 11 cycles at the default.
- `ready` is high for exactly one cycle (DONE). The MEM stage register captures `read_data` on that edge.
- Back-to-back: a new request in the IDLE cycle after DONE starts immediately, so there is 1 idle cycle between accesses.
- With no memory request, `ready` stays high and the block adds zero latency.

## Configuration
- `MEM_RANGE_CHECK_EN` defined:
  - An access with `address < DATA_BASE` or `word ≥ 2^(SRAM_ADDR_W-1)` skips LOW/HIGH and goes IDLE → DONE, so `ready` arrives after 1 cycle.
  - The SRAM is untouched and `read_data` is unchanged.
  - `addr_err` = 1 for the DONE cycle only.
- `MEM_RANGE_CHECK_EN` undefined: no check is made, the address is truncated, and there is no `addr_err` port.

## Structure
- Shared package `arm_mem_pkg` holds:
  - the state enum `mem_state_t` (IDLE, LOW, HIGH, DONE);
  - the default `DATA_BASE` and `WAIT_CYCLES` constants.
- One sub-module, `sram_wait_counter`: counts WAIT_CYCLES, with clear, enable, and a `last` flag at WAIT_CYCLES-1.
- The two `read_data` halves use the existing `Register` module, with enables driven by the FSM.

## Test plan
- Write then read, WAIT_CYCLES=5: store 0xDEADBEEF at 1024, then load 1024.
  - SRAM[0] = 0xBEEF, SRAM[1] = 0xDEAD.
  - `read_data` = 0xDEADBEEF.
  - `ready` high exactly at cycle 11 of each access.
- Strobe timing: store at 1028.
  - `SRAM_ADDR` = 2 then 3.
  - `SRAM_WE_N` low for 4 cycles and high on the 5th of each phase.
  - DQ stable across the rising edge.
- Simultaneous `rd_en` = `wr_en` = 1, address 1032, data 0x12345678: a write occurs and `read_data` is unchanged.
- Reset pulse at cycle 3 of a read of 1024 (holding 0xCAFEF00D):
  - state IDLE, strobes high, `read_data` = 0 after reset.
  - Re-issued read returns 0xCAFEF00D.
- No request for 20 cycles: `ready` stays 1 and the SRAM strobes stay high.
- `MEM_RANGE_CHECK_EN` defined, load from 512:
  - `ready` and `addr_err` high in cycle 1.
  - No `SRAM_OE_N` assertion.
  - `read_data` unchanged.
